// File: rtl/bus_mem_responder_pkg.sv
// bus_mem_responder_pkg
// Shared types and constants for the bus memory responder.
//   BUS_DW / BUS_LENW : data width and burst-length field width of the bus
//   rd_state_e        : read channel states
//   wr_state_e        : write channel states
//   is_final_beat()   : burst termination test shared by both channels
package bus_mem_responder_pkg;

  localparam int BUS_DW   = 32;
  localparam int BUS_LENW = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_BEAT = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // A burst ends on the beat whose index matches the latched length, or
  // early when the initiator marks a beat as last.
  function automatic logic is_final_beat(input logic [BUS_LENW-1:0] cnt,
                                         input logic [BUS_LENW-1:0] len,
                                         input logic                last);
    return (cnt == len) || last;
  endfunction

endpackage

// File: rtl/bus_mem_responder_ram.sv
// bus_mem_responder_ram
// Word-addressed backing RAM: one write port, one synchronous read port.
// A read and a write to the same word on the same edge return the old word.
// The read register only updates when re_i is high, so a stalled beat keeps
// its data even if that word is rewritten meanwhile.
//   clk     : clock
//   clr_i   : synchronous clear of the read data register
//   we_i    : write enable, waddr_i / wdata_i : write port
//   re_i    : read enable,  raddr_i           : read address
//   rdata_o : registered read data
module bus_mem_responder_ram #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder
// Responder end of the simplified cache-side bus, backed by an internal RAM.
// Independent read and write channels, each with its own FSM, latency
// counter, beat counter and word-index incrementer. All outputs registered.
//   clk, resetn                : clock, synchronous active-low reset
//   ce_i                       : chip enable, low aborts both channels
//   ren_i, raddr_i, rlen_i     : read request, byte address, beats-1
//   rready_i                   : initiator accepts the current read beat
//   rdata_o, rvalid_o, rlast_o : read beat data / valid / final beat
//   wen_i, waddr_i, wlen_i     : write request, byte address, beats-1
//   wdata_i, wvalid_i, wlast_i : write beat data / valid / final marker
//   bvalid_o                   : one-cycle write completion pulse
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int MEM_AW        = 12,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ce_i,
  input  logic                ren_i,
  input  logic [BUS_DW-1:0]   raddr_i,
  input  logic [BUS_LENW-1:0] rlen_i,
  input  logic                rready_i,
  output logic [BUS_DW-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                rlast_o,
  input  logic                wen_i,
  input  logic [BUS_DW-1:0]   waddr_i,
  input  logic [BUS_LENW-1:0] wlen_i,
  input  logic [BUS_DW-1:0]   wdata_i,
  input  logic                wvalid_i,
  input  logic                wlast_i,
  output logic                bvalid_o
);

  localparam int RCW = (READ_LATENCY  > 1) ? $clog2(READ_LATENCY)  : 1;
  localparam int WCW = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
  localparam logic [RCW-1:0] R_WAIT_INIT = RCW'(READ_LATENCY - 1);
  localparam logic [WCW-1:0] W_WAIT_INIT = WCW'(WRITE_LATENCY - 1);

  // Read channel state
  rd_state_e           r_state_q;
  logic [MEM_AW-1:0]   r_idx_q;
  logic [BUS_LENW-1:0] r_len_q;
  logic [BUS_LENW-1:0] r_cnt_q;
  logic [RCW-1:0]      r_wait_q;
  logic                rvalid_q;
  logic                rlast_q;

  // Write channel state
  wr_state_e           w_state_q;
  logic [MEM_AW-1:0]   w_idx_q;
  logic [BUS_LENW-1:0] w_len_q;
  logic [BUS_LENW-1:0] w_cnt_q;
  logic [WCW-1:0]      w_wait_q;
  logic                bvalid_q;

  // Byte address bits outside the word index are deliberately ignored,
  // so the RAM aliases across the full 32-bit space.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr_i[BUS_DW-1:MEM_AW+2], raddr_i[1:0],
                              waddr_i[BUS_DW-1:MEM_AW+2], waddr_i[1:0]};

  logic [MEM_AW-1:0] r_base_idx;
  logic [MEM_AW-1:0] w_base_idx;
  assign r_base_idx = raddr_i[MEM_AW+1:2];
  assign w_base_idx = waddr_i[MEM_AW+1:2];

  // ---------------------------------------------------------------------
  // Read-side RAM control. The RAM read is launched one edge ahead of the
  // beat it feeds: the last wait cycle fetches the first word, and each
  // consumed non-final beat fetches the following word.
  // ---------------------------------------------------------------------
  logic r_launch;
  logic r_consume;
  logic r_last_beat;
  logic ram_re;
  logic [MEM_AW-1:0] ram_raddr;

  assign r_launch    = (r_state_q == R_WAIT) && (r_wait_q == '0);
  assign r_consume   = (r_state_q == R_BEAT) && rready_i;
  assign r_last_beat = is_final_beat(r_cnt_q, r_len_q, 1'b0);
  assign ram_re      = resetn && ce_i && (r_launch || (r_consume && !r_last_beat));
  assign ram_raddr   = (r_state_q == R_BEAT) ? r_idx_q + 1'b1 : r_idx_q;

  // ---------------------------------------------------------------------
  // Write-side beat handling. In W_IDLE the accept cycle may also carry a
  // beat, so index/count/length come straight from the request inputs.
  // Accept is held off while bvalid is up because the initiator still
  // drives wen_i during the response cycle.
  // ---------------------------------------------------------------------
  logic                w_accept;
  logic                w_beat;
  logic [MEM_AW-1:0]   w_beat_idx;
  logic [BUS_LENW-1:0] w_beat_cnt;
  logic [BUS_LENW-1:0] w_beat_len;
  logic                w_final;
  logic                ram_we;

  assign w_accept   = ce_i && wen_i && (w_state_q == W_IDLE) && !bvalid_q;
  assign w_beat     = ce_i && wvalid_i && (w_accept || (w_state_q == W_DATA));
  assign w_beat_idx = w_accept ? w_base_idx : w_idx_q;
  assign w_beat_cnt = w_accept ? '0 : w_cnt_q;
  assign w_beat_len = w_accept ? wlen_i : w_len_q;
  assign w_final    = w_beat && is_final_beat(w_beat_cnt, w_beat_len, wlast_i);
  assign ram_we     = resetn && w_beat;

  bus_mem_responder_ram #(
    .AW (MEM_AW),
    .DW (BUS_DW)
  ) u_ram (
    .clk     (clk),
    .clr_i   (!resetn || !ce_i),
    .we_i    (ram_we),
    .waddr_i (w_beat_idx),
    .wdata_i (wdata_i),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (rdata_o)
  );

  // Read FSM
  always_ff @(posedge clk) begin
    if (!resetn || !ce_i) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_wait_q  <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ren_i) begin
            r_idx_q   <= r_base_idx;
            r_len_q   <= rlen_i;
            r_cnt_q   <= '0;
            r_wait_q  <= R_WAIT_INIT;
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_wait_q == '0) begin
            rvalid_q  <= 1'b1;
            rlast_q   <= (r_len_q == '0);
            r_state_q <= R_BEAT;
          end else begin
            r_wait_q <= r_wait_q - 1'b1;
          end
        end
        R_BEAT: begin
          if (rready_i) begin
            if (r_last_beat) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              r_state_q <= R_IDLE;
            end else begin
              r_idx_q <= r_idx_q + 1'b1;
              r_cnt_q <= r_cnt_q + 1'b1;
              rlast_q <= ((r_cnt_q + 1'b1) == r_len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Write FSM
  always_ff @(posedge clk) begin
    if (!resetn || !ce_i) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_wait_q  <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      bvalid_q <= 1'b0;
      case (w_state_q)
        W_IDLE: begin
          if (w_accept) begin
            w_len_q   <= wlen_i;
            w_idx_q   <= w_beat ? w_beat_idx + 1'b1 : w_beat_idx;
            w_cnt_q   <= w_beat ? w_beat_cnt + 1'b1 : w_beat_cnt;
            w_wait_q  <= W_WAIT_INIT;
            w_state_q <= w_final ? W_RESP : W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_idx_q <= w_idx_q + 1'b1;
            w_cnt_q <= w_cnt_q + 1'b1;
            if (w_final) begin
              w_wait_q  <= W_WAIT_INIT;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_wait_q == '0) begin
            bvalid_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end else begin
            w_wait_q <= w_wait_q - 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  assign rlast_o  = rlast_q;
  assign bvalid_o = bvalid_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ce_i;
  logic        ren_i;
  logic [31:0] raddr_i;
  logic [3:0]  rlen_i;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        rlast_o;
  logic        wen_i;
  logic [31:0] waddr_i;
  logic [3:0]  wlen_i;
  logic [31:0] wdata_i;
  logic        wvalid_i;
  logic        wlast_i;
  logic        bvalid_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_mem_responder dut (
    .clk      (clk),
    .resetn   (resetn),
    .ce_i     (ce_i),
    .ren_i    (ren_i),
    .raddr_i  (raddr_i),
    .rlen_i   (rlen_i),
    .rready_i (rready_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .rlast_o  (rlast_o),
    .wen_i    (wen_i),
    .waddr_i  (waddr_i),
    .wlen_i   (wlen_i),
    .wdata_i  (wdata_i),
    .wvalid_i (wvalid_i),
    .wlast_i  (wlast_i),
    .bvalid_o (bvalid_o)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    int n;
    wen_i = 1'b1; waddr_i = addr; wlen_i = 4'd0;
    wdata_i = data; wvalid_i = 1'b1; wlast_i = 1'b1;
    step();
    n = 0;
    while (!bvalid_o && n < 16) begin
      step();
      n++;
    end
    chk("wr_bvalid", {31'd0, bvalid_o}, 32'd1);
    wen_i = 1'b0; wvalid_i = 1'b0; wlast_i = 1'b0;
    step();
    $display("[TB] write %08h <= %08h", addr, data);
  endtask

  task automatic read_word(input logic [31:0] addr, output logic [31:0] data);
    int n;
    ren_i = 1'b1; raddr_i = addr; rlen_i = 4'd0; rready_i = 1'b1;
    step();
    n = 0;
    while (!rvalid_o && n < 16) begin
      step();
      n++;
    end
    chk("rd_rvalid", {31'd0, rvalid_o}, 32'd1);
    data = rdata_o;
    ren_i = 1'b0;
    step();
    $display("[TB] read  %08h => %08h", addr, data);
  endtask

  initial begin
    logic [31:0] got;
    int          k;
    int          n;
    int          bcount;
    bit [6:0]    pat;

    resetn = 1'b0; ce_i = 1'b1;
    ren_i = 1'b0; raddr_i = '0; rlen_i = '0; rready_i = 1'b0;
    wen_i = 1'b0; waddr_i = '0; wlen_i = '0; wdata_i = '0;
    wvalid_i = 1'b0; wlast_i = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rst_rlast",  {31'd0, rlast_o},  32'd0);
    chk("rst_bvalid", {31'd0, bvalid_o}, 32'd0);
    chk("rst_rdata",  rdata_o,           32'd0);
    resetn = 1'b1;
    step();

    // Preload: single writes plus one 8-beat burst (words 0x40..0x47)
    write_word(32'h0000_0040, 32'hDEAD_BEEF);
    write_word(32'h0000_00C0, 32'h0000_000A);
    write_word(32'h0000_0204, 32'h5555_AAAA);
    for (int i = 0; i < 4; i++) write_word(32'h140 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
    wen_i = 1'b1; waddr_i = 32'h100; wlen_i = 4'd7;
    for (int i = 0; i < 8; i++) begin
      wdata_i = 32'h1000_0000 + 32'(i); wvalid_i = 1'b1; wlast_i = (i == 7);
      step();
    end
    n = 0;
    while (!bvalid_o && n < 16) begin
      step();
      n++;
    end
    chk("bwr_bvalid", {31'd0, bvalid_o}, 32'd1);
    wen_i = 1'b0; wvalid_i = 1'b0; wlast_i = 1'b0;
    step();
    $display("[TB] burst write 00000100 x8");

    // Single read latency: accept at E, beat visible from E+2
    ren_i = 1'b1; raddr_i = 32'h40; rlen_i = 4'd0; rready_i = 1'b1;
    step();
    chk("rd1_lat_e0", {31'd0, rvalid_o}, 32'd0);
    step();
    chk("rd1_lat_e1", {31'd0, rvalid_o}, 32'd0);
    step();
    chk("rd1_valid", {31'd0, rvalid_o}, 32'd1);
    chk("rd1_last",  {31'd0, rlast_o},  32'd1);
    chk("rd1_data",  rdata_o,           32'hDEAD_BEEF);
    ren_i = 1'b0;
    step();
    chk("rd1_done", {31'd0, rvalid_o}, 32'd0);
    $display("[TB] read  00000040 single-beat latency check");

    // 8-beat burst, raddr_i scrambled every beat
    ren_i = 1'b1; raddr_i = 32'h100; rlen_i = 4'd7; rready_i = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      chk("brd_valid", {31'd0, rvalid_o}, 32'd1);
      chk("brd_data",  rdata_o, 32'h1000_0000 + 32'(i));
      chk("brd_last",  {31'd0, rlast_o}, (i == 7) ? 32'd1 : 32'd0);
      raddr_i = $urandom;
      step();
    end
    ren_i = 1'b0;
    chk("brd_done", {31'd0, rvalid_o}, 32'd0);
    $display("[TB] burst read 00000100 x8");

    // Single write with wvalid_i held through the response
    wen_i = 1'b1; waddr_i = 32'h200; wlen_i = 4'd0;
    wdata_i = 32'h1234_5678; wvalid_i = 1'b1; wlast_i = 1'b0;
    step();
    chk("wr_resp_e0", {31'd0, bvalid_o}, 32'd0);
    wdata_i = 32'hBAD0_BAD0;
    step();
    chk("wr_resp_e1", {31'd0, bvalid_o}, 32'd1);
    step();
    chk("wr_resp_pulse", {31'd0, bvalid_o}, 32'd0);
    wen_i = 1'b0; wvalid_i = 1'b0;
    step();
    $display("[TB] write 00000200 <= 12345678 (wvalid held)");
    read_word(32'h200, got);
    chk("wr_readback", got, 32'h1234_5678);
    read_word(32'h204, got);
    chk("wr_no_extra", got, 32'h5555_AAAA);

    // 4-beat burst with rready stalls: 1,0,0,1,1,0,1
    pat = 7'b1011001;
    k = 0;
    ren_i = 1'b1; raddr_i = 32'h140; rlen_i = 4'd3; rready_i = 1'b0;
    repeat (3) step();
    for (int j = 0; j < 7; j++) begin
      chk("stall_valid", {31'd0, rvalid_o}, 32'd1);
      chk("stall_data",  rdata_o, 32'hC0DE_0000 + 32'(k));
      chk("stall_last",  {31'd0, rlast_o}, (k == 3) ? 32'd1 : 32'd0);
      rready_i = pat[j];
      step();
      if (pat[j]) k++;
    end
    ren_i = 1'b0; rready_i = 1'b1;
    chk("stall_done", {31'd0, rvalid_o}, 32'd0);
    $display("[TB] burst read 00000140 x4 with stalls");

    // Read fetch and write to word 0x30 on the same edge
    ren_i = 1'b1; raddr_i = 32'hC0; rlen_i = 4'd0; rready_i = 1'b1;
    step();
    step();
    wen_i = 1'b1; waddr_i = 32'hC0; wlen_i = 4'd0;
    wdata_i = 32'h0000_000B; wvalid_i = 1'b1; wlast_i = 1'b1;
    step();
    chk("rw_valid", {31'd0, rvalid_o}, 32'd1);
    chk("rw_old",   rdata_o, 32'h0000_000A);
    ren_i = 1'b0;
    step();
    chk("rw_bvalid", {31'd0, bvalid_o}, 32'd1);
    wen_i = 1'b0; wvalid_i = 1'b0; wlast_i = 1'b0;
    step();
    $display("[TB] read/write collision on 000000C0");
    read_word(32'hC0, got);
    chk("rw_new", got, 32'h0000_000B);

    // Reset in the middle of a burst read
    ren_i = 1'b1; raddr_i = 32'h100; rlen_i = 4'd7; rready_i = 1'b1;
    repeat (5) step();
    resetn = 1'b0; ren_i = 1'b0;
    step();
    chk("mrst_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("mrst_rlast",  {31'd0, rlast_o},  32'd0);
    chk("mrst_rdata",  rdata_o,           32'd0);
    chk("mrst_bvalid", {31'd0, bvalid_o}, 32'd0);
    resetn = 1'b1;
    step();
    $display("[TB] reset during burst read");
    read_word(32'h40, got);
    chk("mrst_fresh", got, 32'hDEAD_BEEF);

    // Chip enable dropped mid-burst-write
    wen_i = 1'b1; waddr_i = 32'h300; wlen_i = 4'd3;
    wdata_i = 32'h7777_0000; wvalid_i = 1'b1; wlast_i = 1'b0;
    step();
    wdata_i = 32'h7777_0001;
    step();
    ce_i = 1'b0; wen_i = 1'b0; wvalid_i = 1'b0;
    step();
    chk("ce_bvalid", {31'd0, bvalid_o}, 32'd0);
    chk("ce_rvalid", {31'd0, rvalid_o}, 32'd0);
    ce_i = 1'b1;
    bcount = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bvalid_o) bcount++;
    end
    chk("ce_no_bvalid", 32'(bcount), 32'd0);
    $display("[TB] chip enable dropped during burst write 00000300");
    read_word(32'h300, got);
    chk("ce_kept0", got, 32'h7777_0000);
    read_word(32'h304, got);
    chk("ce_kept1", got, 32'h7777_0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
